// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO that buffers ALU results
// together with flags derived at push time (zero, negative, masked carry).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, in_ready       producer handshake (in_ready is combinational)
//   in_f, in_cout, in_sel    ALU result, carry-out and opcode
//   out_valid, out_ready     consumer handshake for the head entry
//   out_f, out_cout, out_sel head entry payload (registered)
//   out_zero, out_neg        head entry flags (registered)
//   count                    number of stored entries
//   drop_err, clr_err        sticky "result lost" flag and its clear
module alu_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_f,
    input  logic                       in_cout,
    input  logic [2:0]                 in_sel,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_f,
    output logic                       out_cout,
    output logic [2:0]                 out_sel,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop_err,
    input  logic                       clr_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic             cout;
        logic [2:0]       sel;
        logic             zero;
        logic             neg;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d, remaining;
    entry_t          mem [DEPTH];
    entry_t          head_q, head_d, in_entry;
    logic            push, pop, drop;

    // Flags are captured at push; carry is only meaningful for add/sub opcodes.
    always_comb begin
        in_entry.f    = in_f;
        in_entry.cout = ((in_sel == 3'b011) || (in_sel == 3'b100)) ? in_cout : 1'b0;
        in_entry.sel  = in_sel;
        in_entry.zero = (in_f == '0);
        in_entry.neg  = in_f[WIDTH-1];
    end

    // Full FIFO may still accept when the head leaves in the same cycle.
    assign in_ready  = !rst && ((state_q != FULL) || out_ready);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign drop      = in_valid && !in_ready;

    // Next-state, next-count and next-head selection.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        head_d    = head_q;
        remaining = count_q - CW'(pop);

        case (state_q)
            EMPTY:   if (push) state_d = PARTIAL;
            PARTIAL: begin
                if (push && !pop && (count_q == CW'(DEPTH - 1)))
                    state_d = FULL;
                else if (pop && !push && (count_q == CW'(1)))
                    state_d = EMPTY;
            end
            FULL:    if (pop && !push) state_d = PARTIAL;
            default: state_d = EMPTY;
        endcase

        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);

        // Head register changes only when the head entry is replaced; when no
        // older entry survives the pop, the new head is the one being pushed.
        if ((count_d != '0) && (pop || (state_q == EMPTY)))
            head_d = (push && (remaining == '0)) ? in_entry : mem[rd_ptr_q + PW'(pop)];
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            drop_err <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            head_q  <= head_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (drop)
                drop_err <= 1'b1;
            else if (clr_err)
                drop_err <= 1'b0;
        end
    end

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_entry;
    end

    assign out_f    = head_q.f;
    assign out_cout = head_q.cout;
    assign out_sel  = head_q.sel;
    assign out_zero = head_q.zero;
    assign out_neg  = head_q.neg;
    assign count    = count_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed bench for alu_result_fifo with a queue-based
// reference model checked every cycle plus hand-computed literal pins.
module tb_alu_result_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_f = '0;
    logic             in_cout = 1'b0;
    logic [2:0]       in_sel = 3'b000;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_f;
    logic             out_cout;
    logic [2:0]       out_sel;
    logic             out_zero;
    logic             out_neg;
    logic [CW-1:0]    count;
    logic             drop_err;
    logic             clr_err = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_f     (in_f),
        .in_cout  (in_cout),
        .in_sel   (in_sel),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_f    (out_f),
        .out_cout (out_cout),
        .out_sel  (out_sel),
        .out_zero (out_zero),
        .out_neg  (out_neg),
        .count    (count),
        .drop_err (drop_err),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] f;
        logic             cout;
        logic [2:0]       sel;
        logic             zero;
        logic             neg;
    } exp_t;

    exp_t q[$];
    exp_t last_head = '{f: '0, cout: 1'b0, sel: 3'b000, zero: 1'b0, neg: 1'b0};
    logic m_drop = 1'b0;

    function automatic exp_t mk(input logic [WIDTH-1:0] f, input logic c, input logic [2:0] s);
        exp_t e;
        e.f    = f;
        e.cout = (s == 3'd3 || s == 3'd4) ? c : 1'b0;
        e.sel  = s;
        e.zero = (f == 0);
        e.neg  = f[WIDTH-1];
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return !rst && ((q.size() < DEPTH) || out_ready);
    endfunction

    // Reference model: a queue of entries, updated at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_drop    = 1'b0;
            last_head = '{f: '0, cout: 1'b0, sel: 3'b000, zero: 1'b0, neg: 1'b0};
        end else begin
            logic rdy, do_push, do_pop;
            rdy     = m_ready();
            do_push = in_valid && rdy;
            do_pop  = (q.size() != 0) && out_ready;
            if (in_valid && !rdy) m_drop = 1'b1;
            else if (clr_err)     m_drop = 1'b0;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(mk(in_f, in_cout, in_sel));
            if (q.size() != 0) last_head = q[0];
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_in_ready",  64'(in_ready),  64'(m_ready()));
        chk("cmp_out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("cmp_count",     64'(count),     64'(q.size()));
        chk("cmp_drop_err",  64'(drop_err),  64'(m_drop));
        chk("cmp_out_f",     64'(out_f),     64'(last_head.f));
        chk("cmp_out_cout",  64'(out_cout),  64'(last_head.cout));
        chk("cmp_out_sel",   64'(out_sel),   64'(last_head.sel));
        chk("cmp_out_zero",  64'(out_zero),  64'(last_head.zero));
        chk("cmp_out_neg",   64'(out_neg),   64'(last_head.neg));
    end

    // Apply one cycle of inputs, then return to idle shortly after the edge.
    task automatic step(input logic iv, input logic [WIDTH-1:0] f, input logic c,
                        input logic [2:0] s, input logic ordy, input logic clr,
                        input logic r);
        in_valid  = iv;
        in_f      = f;
        in_cout   = c;
        in_sel    = s;
        out_ready = ordy;
        clr_err   = clr;
        rst       = r;
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] f);
        step(1'b1, f, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, '0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset: in_ready low while rst held, outputs cleared.
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_valid",    64'(out_valid), 64'd0);
        chk("rst_out_f",    64'(out_f),    64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single push of zero with add opcode: carry kept, zero flag set.
        step(1'b1, 32'h0000_0000, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
        chk("p1_valid", 64'(out_valid), 64'd1);
        chk("p1_zero",  64'(out_zero),  64'd1);
        chk("p1_neg",   64'(out_neg),   64'd0);
        chk("p1_cout",  64'(out_cout),  64'd1);
        chk("p1_count", 64'(count),     64'd1);
        pop();
        chk("p1_empty", 64'(out_valid), 64'd0);
        chk("p1_hold",  64'(out_cout),  64'd1);

        // Carry masked for a non add/sub opcode.
        step(1'b1, 32'h8000_0001, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("mask_cout", 64'(out_cout), 64'd0);
        chk("mask_neg",  64'(out_neg),  64'd1);
        chk("mask_zero", 64'(out_zero), 64'd0);
        pop();

        // Fill and overflow; opcode 3'b111 stored unchanged.
        for (int v = 1; v <= 5; v++)
            step(1'b1, 32'(v), 1'b1, (v == 2) ? 3'b111 : 3'b000, 1'b0, 1'b0, 1'b0);
        chk("ovf_count",    64'(count),    64'd4);
        chk("ovf_in_ready", 64'(in_ready), 64'd0);
        chk("ovf_drop",     64'(drop_err), 64'd1);
        for (int v = 1; v <= 4; v++) begin
            chk("ovf_order", 64'(out_f), 64'(v));
            if (v == 2) chk("ovf_sel111", 64'(out_sel), 64'd7);
            pop();
        end
        chk("ovf_drained", 64'(out_valid), 64'd0);

        // Clear, then refill and drop while clearing: set wins.
        step(1'b0, '0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("clr_drop", 64'(drop_err), 64'd0);
        for (int v = 10; v <= 13; v++) push(32'(v));
        step(1'b1, 32'd99, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("setwins_drop", 64'(drop_err), 64'd1);

        // Full with simultaneous push and pop.
        step(1'b1, 32'd20, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
        chk("fullpp_count", 64'(count),    64'd4);
        chk("fullpp_drop",  64'(drop_err), 64'd1);
        chk("fullpp_head",  64'(out_f),    64'd11);
        for (int i = 0; i < 4; i++) begin
            chk("fullpp_order", 64'(out_f), (i == 3) ? 64'd20 : 64'(11 + i));
            pop();
        end

        // Wrap-around: overlapping push/pop keeps one entry in flight.
        push(32'd0);
        for (int v = 1; v <= 9; v++) begin
            chk("wrap_head",  64'(out_f), 64'(v - 1));
            chk("wrap_count", 64'(count), 64'd1);
            step(1'b1, 32'(v), 1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
        end
        chk("wrap_last", 64'(out_f), 64'd9);
        pop();
        chk("wrap_empty", 64'(count), 64'd0);

        // Reset mid-operation with entries and the error flag set.
        for (int v = 30; v <= 32; v++) push(32'(v));
        chk("mid_count", 64'(count),    64'd3);
        chk("mid_drop",  64'(drop_err), 64'd1);
        step(1'b1, 32'd55, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1);
        chk("mid_rst_count", 64'(count),     64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_drop",  64'(drop_err),  64'd0);
        chk("mid_rst_f",     64'(out_f),     64'd0);
        push(32'd77);
        chk("mid_next", 64'(out_f), 64'd77);
        pop();

        // Mixed traffic; the per-cycle model comparison covers it.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of result entries; legal values are 2, 4, 8 and 16.
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the ALU result width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the ALU result on in_f, in_cout and in_sel is valid this cycle.
REQ-006 The block SHALL have port in_f, input, WIDTH bits: the ALU output F.
REQ-007 The block SHALL have port in_cout, input, 1 bit: the ALU carry-out Cout.
REQ-008 The block SHALL have port in_sel, input, 3 bits: the ALU opcode that produced the result.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept an entry this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the head entry is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head entry this cycle.
REQ-012 The block SHALL have ports out_f (WIDTH), out_cout (1), out_sel (3), out_zero (1) and out_neg (1), all outputs, carrying the head entry and its flags.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of stored entries.
REQ-014 The block SHALL have port drop_err, output, 1 bit: a sticky flag indicating that a result was lost.
REQ-015 The block SHALL have port clr_err, input, 1 bit: clears drop_err.

Function
REQ-016 A push SHALL occur when in_valid=1 and in_ready=1; a pop SHALL occur when out_valid=1 and out_ready=1.
REQ-017 in_ready SHALL equal (count<DEPTH) OR out_ready; a simultaneous push and pop when full is legal.
REQ-018 At push, the stored flags SHALL be computed as follows: zero = (in_f==0); neg = in_f[WIDTH-1]; cout = in_cout only when in_sel is 3'b011 or 3'b100, otherwise cout = 0.
REQ-019 in_sel values 3'b111 SHALL be stored unchanged, with the result stored as given.
REQ-020 The output SHALL be first-word-fall-through: an entry pushed at edge N into an empty FIFO SHALL present out_valid=1 with its data from edge N onward, so it is visible in cycle N+1.
REQ-021 out_f, out_cout, out_sel, out_zero and out_neg SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 When count=0, out_valid SHALL be 0 and the data outputs SHALL hold their last value; a push and pop are never both performed on an empty FIFO in the same cycle (no bypass).
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 count SHALL update as follows: +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop or on no operation.
REQ-025 When in_valid=1 and in_ready=0, the input SHALL be discarded, drop_err SHALL be set at the next edge, and no FIFO state SHALL change.
REQ-026 clr_err=1 SHALL clear drop_err at the next edge; if a drop occurs in the same cycle, the set SHALL win.
REQ-027 The FIFO control SHALL have states EMPTY (count=0), PARTIAL and FULL (count=DEPTH), with transitions governed solely by push and pop as defined in REQ-024.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set the pointers to 0, count=0, out_valid=0, drop_err=0, and out_f, out_cout, out_sel, out_zero and out_neg all to 0.
REQ-029 Reset SHALL take priority over push, pop and clr_err, and all entries in flight SHALL be discarded.
REQ-030 During the rst=1 cycle, in_ready SHALL be 0; from the first cycle after reset deasserts, in_ready SHALL be 1.

Verification
REQ-031 Single push, empty FIFO: in_f=32'h0000_0000, in_sel=3'b011, in_cout=1, out_ready=0 -> next cycle out_valid=1, out_zero=1, out_neg=0, out_cout=1, count=1.
REQ-032 Carry masking: in_f=32'h8000_0001, in_sel=3'b010, in_cout=1 -> out_cout=0, out_neg=1, out_zero=0.
REQ-033 Fill and overflow, DEPTH=4, out_ready=0: five pushes of values 1..5 -> count=4, in_ready=0, value 5 dropped, drop_err=1; popping then yields 1, 2, 3, 4 in order.
REQ-034 Full with simultaneous push and pop: with the FIFO full, in_valid=1 and out_ready=1 -> count stays 4, drop_err unchanged, and the new entry appears after the three older entries.
REQ-035 Wrap-around: ten push/pop pairs with values 0..9 -> output order is exactly 0..9 and count never exceeds 1.
REQ-036 Reset mid-operation: with count=3 and drop_err=1, assert rst for one cycle -> count=0, out_valid=0, drop_err=0, and the next pushed value is the next value popped.
